// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: two-port arbiter in front of a single-port data memory.
// Serves one access per cycle, returns read data / write ack one cycle later.
//
// Ports:
//   clock, reset           : system clock, synchronous active-high reset
//   pX_req/we/addr/wdata   : requester X (X = 0,1) access request
//   pX_gnt/rvalid/rdata/err: grant pulse, response pulse, read data, range error
//   mem_we/addr/wdata      : memory write enable, address, write data
//   mem_rdata              : combinational read data of mem_addr
//
// Configuration macro: ARB_ROUND_ROBIN_EN
//   defined   : on simultaneous requests grant the port that was not granted last
//   undefined : fixed priority, port 0 always wins
module data_mem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 20
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_err,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERVE0 = 2'd1,
    SERVE1 = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic [1:0]        rvalid_q, err_q;
  logic [DATA_W-1:0] rd0_q, rd1_q;

  logic              serving;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              in_range;

  // Next grant from the requests sampled at this edge.
  always_comb begin
    state_d = IDLE;
`ifdef ARB_ROUND_ROBIN_EN
    if (p0_req && p1_req) begin
      state_d = last_q ? SERVE0 : SERVE1;
    end else if (p0_req) begin
      state_d = SERVE0;
    end else if (p1_req) begin
      state_d = SERVE1;
    end
`else
    if (p0_req) begin
      state_d = SERVE0;
    end else if (p1_req) begin
      state_d = SERVE1;
    end
`endif
    last_d = last_q;
    if (state_d == SERVE0) begin
      last_d = 1'b0;
    end else if (state_d == SERVE1) begin
      last_d = 1'b1;
    end
  end

  // Memory side follows the served port; reset kills the access at once.
  assign serving   = (state_q != IDLE) && !reset;
  assign sel_we    = (state_q == SERVE1) ? p1_we    : p0_we;
  assign sel_addr  = (state_q == SERVE1) ? p1_addr  : p0_addr;
  assign sel_wdata = (state_q == SERVE1) ? p1_wdata : p0_wdata;
  assign in_range  = sel_addr < ADDR_W'(MEM_DEPTH);

  assign mem_we    = serving && sel_we && in_range;
  assign mem_addr  = serving ? sel_addr  : '0;
  assign mem_wdata = serving ? sel_wdata : '0;

  assign p0_gnt    = !reset && (state_q == SERVE0);
  assign p1_gnt    = !reset && (state_q == SERVE1);
  assign p0_rvalid = !reset && rvalid_q[0];
  assign p1_rvalid = !reset && rvalid_q[1];
  assign p0_err    = !reset && err_q[0];
  assign p1_err    = !reset && err_q[1];
  assign p0_rdata  = reset ? '0 : rd0_q;
  assign p1_rdata  = reset ? '0 : rd1_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      rvalid_q <= '0;
      err_q    <= '0;
      rd0_q    <= '0;
      rd1_q    <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      rvalid_q <= '0;
      err_q    <= '0;
      if (state_q == SERVE0) begin
        rvalid_q[0] <= 1'b1;
        err_q[0]    <= !in_range;
        if (!in_range) begin
          rd0_q <= '0;
        end else if (!sel_we) begin
          rd0_q <= mem_rdata;
        end
      end
      if (state_q == SERVE1) begin
        rvalid_q[1] <= 1'b1;
        err_q[1]    <= !in_range;
        if (!in_range) begin
          rd1_q <= '0;
        end else if (!sel_we) begin
          rd1_q <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, width of requester and memory addresses.
REQ-002 Parameter: DATA_W, 32, width of data words.
REQ-003 Parameter: MEM_DEPTH, 20, number of valid data-memory words; legal addresses are 0..MEM_DEPTH-1.
REQ-004 Ports: clock in 1 system clock; reset in 1 synchronous active-high reset (one clock; reset synchronous, active-high).
REQ-005 Ports, x in {0,1}: px_req in 1 access request; px_we in 1 write(1)/read(0); px_addr in ADDR_W word address; px_wdata in DATA_W write data.
REQ-006 Ports, x in {0,1}: px_gnt out 1 grant pulse; px_rvalid out 1 response pulse; px_rdata out DATA_W read data; px_err out 1 out-of-range pulse.
REQ-007 Ports: mem_we out 1; mem_addr out ADDR_W; mem_wdata out DATA_W; mem_rdata in DATA_W, combinational read of mem_addr.

Function
REQ-008 FSM states IDLE, SERVE0, SERVE1; SERVEx drives memory from port x for exactly one cycle.
REQ-009 Arbitration is evaluated in every state on sampled px_req; the result is registered as next state; no request -> IDLE.
REQ-010 In SERVEx: px_gnt=1; mem_addr=px_addr; mem_wdata=px_wdata; mem_we=px_we AND (px_addr<MEM_DEPTH).
REQ-011 Outside SERVEx: px_gnt=0; when IDLE, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-012 Requester holds req/we/addr/wdata stable from assertion until the cycle px_gnt=1; keeping req high after gnt requests a new access.
REQ-013 Latency: req sampled in cycle N -> gnt in N+1 -> rvalid in N+2; back-to-back throughput one access per cycle.
REQ-014 Read in SERVEx: mem_rdata registered at end of cycle into px_rdata; px_rvalid=1 for one cycle next cycle.
REQ-015 Write in SERVEx: px_rvalid pulses next cycle as write acknowledge; px_rdata unchanged.
REQ-016 px_addr>=MEM_DEPTH: access still granted; no write; px_rdata loaded with 0; px_err=1 together with px_rvalid.
REQ-017 px_rdata holds its value between responses; rvalid/err/gnt are single-cycle pulses.
REQ-018 The arbiter keeps a last_grant register (0 or 1), updated on every SERVEx entry.
REQ-019 A single requester is always granted; simultaneous requests are resolved per REQ-026.
REQ-020 The port granted in cycle N may be granted again in cycle N+1 if it is the only requester or wins arbitration.
REQ-021 Arbitration samples px_req at the cycle edge, including during the port's own grant cycle, so continuous req yields continuous grants.

Reset
REQ-022 reset=1 at a clock edge overrides all other inputs; state=IDLE, last_grant=1.
REQ-023 During and after reset: all outputs 0, px_rdata=0.
REQ-024 Reset in SERVEx aborts that access: no rvalid/err for it; a write in that cycle is suppressed since mem_we is forced 0.
REQ-025 First cycle after reset deassertion: arbitration restarts from IDLE.

Configuration
REQ-026 Macro ARB_ROUND_ROBIN_EN defined: on simultaneous requests grant the port != last_grant; undefined: fixed priority, port 0 always wins and port 1 may starve.

Verification
REQ-027 Reset, then p0 write addr 3 data 0xA5A5A5A5 -> p0_gnt in cycle 1 with mem_we=1, mem_addr=3; p0_rvalid in cycle 2; p0_err=0.
REQ-028 p1 read addr 3 after REQ-027 -> p1_gnt next cycle; p1_rvalid following cycle with p1_rdata=0xA5A5A5A5.
REQ-029 p0 and p1 requesting continuously for 6 cycles -> with macro grants alternate 0,1,0,1,0,1 (last_grant reset 1); without macro six grants to p0, zero to p1.
REQ-030 p0 write addr 25 (MEM_DEPTH 20) -> p0_gnt, mem_we=0, p0_rvalid with p0_err=1, p0_rdata=0; memory contents unchanged.
REQ-031 reset asserted during SERVE1 of a p1 write -> mem_we=0 that cycle, no p1_rvalid, all outputs 0, state IDLE next cycle.
